// File: rtl/fft_out_requant.sv
// fft_out_requant: round/saturate FFT output stream to OUT_W bits and tag frames; define FFT_REQUANT_STATS_EN for per-frame saturation counts
module fft_out_requant #(
  parameter int N      = 64,
  parameter int IN_W   = 32,
  parameter int IN_FW  = 15,
  parameter int OUT_W  = 16,
  parameter int OUT_FW = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [IN_W-1:0]        s_re,
  input  logic [IN_W-1:0]        s_im,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [OUT_W-1:0]       m_re,
  output logic [OUT_W-1:0]       m_im,
  output logic                   m_sat,
  output logic                   m_last,
  output logic                   frame_done,
  output logic [$clog2(N+1)-1:0] frame_sat
);
  localparam int SHIFT = IN_FW - OUT_FW;
  localparam int CW = $clog2(N + 1);
  localparam int IW = $clog2(N);
  localparam logic signed [IN_W:0] RND = SHIFT == 0 ? '0 : (IN_W+1)'(1) << (SHIFT == 0 ? 0 : SHIFT - 1);
  localparam logic signed [IN_W:0] MAXV = (IN_W+1)'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [IN_W:0] MINV = ~MAXV;
  if (SHIFT < 0 || SHIFT > IN_W - 2) begin : g_bad_shift
    $error("fft_out_requant: IN_FW-OUT_FW out of range");
  end
  function automatic logic signed [IN_W:0] rnd(input logic [IN_W-1:0] x);
    return ($signed({x[IN_W-1], x}) + RND) >>> SHIFT;
  endfunction
  function automatic logic [OUT_W:0] sat(input logic signed [IN_W:0] r);
    return r > MAXV ? {1'b1, MAXV[OUT_W-1:0]} : r < MINV ? {1'b1, MINV[OUT_W-1:0]} : {1'b0, r[OUT_W-1:0]};
  endfunction
  logic en1, en2, xfer;
  logic v1_q, v1_d, last1_q, last1_d, v2_q, v2_d, sat2_q, sat2_d, last2_q, last2_d, done_q, done_d;
  logic signed [IN_W:0] re1_q, re1_d, im1_q, im1_d;
  logic [OUT_W-1:0] re2_q, re2_d, im2_q, im2_d;
  logic [OUT_W:0] sr, si;
  logic [IW-1:0] in_cnt_q, in_cnt_d;
  // two-stage elastic pipeline: stage 1 rounds, stage 2 saturates; each stage loads when it is empty or draining
  always_comb begin
    en2 = !v2_q || m_ready;
    en1 = !v1_q || en2;
    xfer = v2_q && m_ready;
    sr = sat(re1_q);
    si = sat(im1_q);
    in_cnt_d = (s_valid && en1) ? (in_cnt_q == IW'(N - 1) ? '0 : in_cnt_q + 1'b1) : in_cnt_q;
    v1_d = en1 ? s_valid : v1_q;
    re1_d = en1 ? rnd(s_re) : re1_q;
    im1_d = en1 ? rnd(s_im) : im1_q;
    last1_d = en1 ? in_cnt_q == IW'(N - 1) : last1_q;
    v2_d = en2 ? v1_q : v2_q;
    re2_d = en2 ? sr[OUT_W-1:0] : re2_q;
    im2_d = en2 ? si[OUT_W-1:0] : im2_q;
    sat2_d = en2 ? sr[OUT_W] | si[OUT_W] : sat2_q;
    last2_d = en2 ? last1_q : last2_q;
    done_d = xfer && last2_q;
  end
  // pipeline and frame-position state
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      re1_q <= '0;
      im1_q <= '0;
      last1_q <= 1'b0;
      v2_q <= 1'b0;
      re2_q <= '0;
      im2_q <= '0;
      sat2_q <= 1'b0;
      last2_q <= 1'b0;
      done_q <= 1'b0;
      in_cnt_q <= '0;
    end else begin
      v1_q <= v1_d;
      re1_q <= re1_d;
      im1_q <= im1_d;
      last1_q <= last1_d;
      v2_q <= v2_d;
      re2_q <= re2_d;
      im2_q <= im2_d;
      sat2_q <= sat2_d;
      last2_q <= last2_d;
      done_q <= done_d;
      in_cnt_q <= in_cnt_d;
    end
  end
  assign s_ready = en1;
  assign m_valid = v2_q;
  assign m_re = re2_q;
  assign m_im = im2_q;
  assign m_sat = sat2_q;
  assign m_last = last2_q;
  assign frame_done = done_q;
`ifdef FFT_REQUANT_STATS_EN
  logic [CW-1:0] sat_acc_q, sat_acc_d, frame_sat_q, frame_sat_d;
  // count saturated beats within a frame and publish the total on the frame's last transfer
  always_comb begin
    sat_acc_d = xfer ? (last2_q ? '0 : sat_acc_q + CW'(sat2_q)) : sat_acc_q;
    frame_sat_d = (xfer && last2_q) ? sat_acc_q + CW'(sat2_q) : frame_sat_q;
  end
  // statistics registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_acc_q <= '0;
      frame_sat_q <= '0;
    end else begin
      sat_acc_q <= sat_acc_d;
      frame_sat_q <= frame_sat_d;
    end
  end
  assign frame_sat = frame_sat_q;
`else
  assign frame_sat = '0;
`endif
endmodule
